// File: rtl/data_mem_bridge_pkg.sv
// rtl/data_mem_bridge_pkg.sv - shared types and constants for the data-memory bridge
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

    localparam int DEFAULT_TIMEOUT = 256;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr & ~32'h3;
    endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// rtl/data_mem_bridge_if.sv - valid/ready memory bus between the bridge and external memory
interface data_mem_bridge_if;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );

endinterface

// File: rtl/data_mem_bridge_watchdog.sv
// rtl/data_mem_bridge_watchdog.sv - clear/enable cycle counter with terminal-count flag
module bridge_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    // Terminal count only matters while the counter is actually timing an access.
    assign tc = enable && (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - multi-cycle bridge from core memory requests to a valid/ready bus
module data_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              addr,
    input  logic [31:0]              w_data,
    input  logic [3:0]               byte_enable,
    output logic [31:0]              r_data,
    output logic                     stall,
    output logic                     access_err,
    data_mem_bridge_if.master        bus
);

    state_t   state;
    state_t   state_next;
    bus_req_t req_q;
    logic     err_q;
    logic     access;
    logic     wd_clear;
    logic     wd_en;
    logic     wd_tc;

    assign access   = mem_read | mem_write;
    assign wd_clear = (state == IDLE) && access;
    assign wd_en    = (state == REQ) || (state == WAIT);

    bridge_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_en),
        .tc     (wd_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In REQ the watchdog wins over a same-cycle accept: the access is abandoned.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access) state_next = REQ;
            REQ: begin
                if (wd_tc) begin
                    state_next = DONE;
                end else if (bus.bus_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: if (bus.bus_rsp_valid || wd_tc) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall             = 1'b0;
        access_err        = 1'b0;
        bus.bus_req_valid = 1'b0;
        case (state)
            IDLE: stall = access;
            REQ: begin
                stall             = 1'b1;
                bus.bus_req_valid = 1'b1;
            end
            WAIT: stall = 1'b1;
            DONE: access_err = err_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q  <= '0;
            r_data <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        req_q.we    <= mem_write;
                        req_q.addr  <= word_addr(addr);
                        req_q.wdata <= w_data;
                        req_q.be    <= mem_write ? byte_enable : 4'b0000;
                        err_q       <= 1'b0;
                    end
                end
                REQ: begin
                    if (wd_tc) begin
                        err_q  <= 1'b1;
                        r_data <= '0;
                    end
                end
                WAIT: begin
                    if (bus.bus_rsp_valid) begin
                        err_q <= bus.bus_rsp_err;
                        if (!req_q.we) begin
                            r_data <= bus.bus_rsp_rdata;
                        end
                    end else if (wd_tc) begin
                        err_q  <= 1'b1;
                        r_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req_we    = req_q.we;
    assign bus.bus_req_addr  = req_q.addr;
    assign bus.bus_req_wdata = req_q.wdata;
    assign bus.bus_req_be    = req_q.be;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - randomized scoreboard bench for data_mem_bridge
module tb_data_mem_bridge;

    localparam int TMO = 8;

    typedef struct {
        bit          rd_en;
        bit          wr_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          rd;
        int          rsp;
        bit          no_rsp;
        logic [31:0] rdata;
        bit          err;
        int          gap;
        bit          tmo;
    } txn_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  byte_enable = '0;
    logic [31:0] r_data;
    logic        stall;
    logic        access_err;

    int checks = 0;
    int fails  = 0;
    bit slave_en = 1'b1;

    txn_t  plan_q[$];
    req_t  req_q[$];
    done_t done_q[$];
    logic [31:0] model_rdata = '0;

    data_mem_bridge_if bus_if ();

    data_mem_bridge #(
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .w_data      (w_data),
        .byte_enable (byte_enable),
        .r_data      (r_data),
        .stall       (stall),
        .access_err  (access_err),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus slave: plays back each transaction's planned ready/response timing.
    initial begin
        txn_t p;
        req_t r;
        int   cnt;
        bit   accepted;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_rdata = '0;
        bus_if.bus_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (slave_en && rst && bus_if.bus_req_valid) begin
                if (plan_q.size() == 0 || req_q.size() == 0) begin
                    chk("unplanned_request", 32'd1, 32'd0);
                end else begin
                    p = plan_q.pop_front();
                    r = req_q.pop_front();
                    cnt = 0;
                    accepted = 1'b0;
                    while (bus_if.bus_req_valid && !accepted) begin
                        chk("req_we", 32'(bus_if.bus_req_we), 32'(r.we));
                        chk("req_addr", bus_if.bus_req_addr, r.addr);
                        chk("req_wdata", bus_if.bus_req_wdata, r.wdata);
                        chk("req_be", 32'(bus_if.bus_req_be), 32'(r.be));
                        if (cnt == p.rd) begin
                            bus_if.bus_req_ready = 1'b1;
                            @(negedge clk);
                            bus_if.bus_req_ready = 1'b0;
                            accepted = 1'b1;
                        end else begin
                            cnt++;
                            @(negedge clk);
                        end
                    end
                    if (accepted && !p.tmo) begin
                        repeat (p.rsp - 1) @(negedge clk);
                        bus_if.bus_rsp_valid = 1'b1;
                        bus_if.bus_rsp_rdata = p.rdata;
                        bus_if.bus_rsp_err   = p.err;
                        @(negedge clk);
                        bus_if.bus_rsp_valid = 1'b0;
                        bus_if.bus_rsp_err   = 1'b0;
                        bus_if.bus_rsp_rdata = $urandom;
                    end
                end
            end
        end
    end

    // Completion monitor: an access with stall low is the retiring cycle.
    int          stall_cnt = 0;
    logic [31:0] last_rdata = '0;
    always @(negedge clk) begin
        done_t e;
        if (!rst) begin
            stall_cnt  = 0;
            last_rdata = '0;
        end else begin
            if (stall) stall_cnt++;
            if ((mem_read || mem_write) && !stall) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_rdata", r_data, e.rdata);
                    chk("done_err", 32'(access_err), 32'(e.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    last_rdata = e.rdata;
                end
                stall_cnt = 0;
            end else begin
                chk("err_outside_done", 32'(access_err), 32'd0);
                chk("rdata_hold", r_data, last_rdata);
            end
        end
    end

    function automatic txn_t mk(bit rd_en, bit wr_en, logic [31:0] a, logic [31:0] wd,
                                logic [3:0] be, int rd, int rsp, bit no_rsp,
                                logic [31:0] rdata, bit err, int gap);
        txn_t t;
        t.rd_en = rd_en; t.wr_en = wr_en; t.addr = a; t.wdata = wd; t.be = be;
        t.rd = rd; t.rsp = rsp; t.no_rsp = no_rsp; t.rdata = rdata; t.err = err;
        t.gap = gap; t.tmo = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int k = $urandom_range(0, 9);
        return mk(k >= 4, (k < 4) || (k == 9), $urandom, $urandom,
                  4'($urandom_range(1, 15)),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 3),
                  $urandom_range(1, 4), $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2));
    endfunction

    task automatic issue(input txn_t t);
        req_t  r;
        done_t d;
        int    total;
        int    n;
        total = t.rd + 1 + t.rsp;
        t.tmo = t.no_rsp || (total > TMO);
        r.we    = t.wr_en;
        r.addr  = {t.addr[31:2], 2'b00};
        r.wdata = t.wdata;
        r.be    = t.wr_en ? t.be : 4'b0000;
        if (t.tmo) begin
            d.rdata = '0;
            d.err   = 1'b1;
            d.stall = 1 + TMO;
        end else begin
            d.rdata = t.wr_en ? model_rdata : t.rdata;
            d.err   = t.err;
            d.stall = 1 + total;
        end
        model_rdata = d.rdata;
        plan_q.push_back(t);
        req_q.push_back(r);
        done_q.push_back(d);
        mem_read    = t.rd_en;
        mem_write   = t.wr_en;
        addr        = t.addr;
        w_data      = t.wdata;
        byte_enable = t.be;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (stall && n < 100);
        if (n >= 100) chk("access_completes", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (t.gap > 0) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            repeat (t.gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        txn_t dir[$];
        int   n;

        repeat (2) @(negedge clk);
        chk("rst_r_data", r_data, 32'd0);
        chk("rst_access_err", 32'(access_err), 32'd0);
        chk("rst_req_valid", 32'(bus_if.bus_req_valid), 32'd0);
        chk("rst_req_we", 32'(bus_if.bus_req_we), 32'd0);
        chk("rst_req_addr", bus_if.bus_req_addr, 32'd0);
        chk("rst_req_wdata", bus_if.bus_req_wdata, 32'd0);
        chk("rst_req_be", 32'(bus_if.bus_req_be), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("idle_no_stall", 32'(stall), 32'd0);

        dir.push_back(mk(1, 0, 32'h0000_1006, 32'h0, 4'hF, 0, 1, 0, 32'hDEAD_BEEF, 0, 1));
        dir.push_back(mk(0, 1, 32'h0000_2000, 32'h0000_1234, 4'b0011, 5, 1, 0, 32'h0, 0, 1));
        dir.push_back(mk(1, 0, 32'h0000_3008, 32'h0, 4'hF, 0, 1, 1, 32'h0, 0, 1));
        dir.push_back(mk(1, 0, 32'h0000_400C, 32'h0, 4'hF, 1, 2, 0, 32'h5555_AAAA, 1, 1));
        dir.push_back(mk(1, 1, 32'h0000_5003, 32'hCAFE_F00D, 4'hF, 0, 1, 0, 32'h0, 0, 1));
        dir.push_back(mk(1, 0, 32'h0000_6000, 32'h0, 4'h0, 0, 1, 0, 32'h1111_2222, 0, 0));
        dir.push_back(mk(1, 0, 32'h0000_6004, 32'h0, 4'h0, 0, 2, 0, 32'h3333_4444, 0, 0));
        dir.push_back(mk(1, 0, 32'h0000_7000, 32'h0, 4'h0, 3, 4, 0, 32'h7777_8888, 0, 1));
        dir.push_back(mk(1, 0, 32'h0000_8000, 32'h0, 4'h0, 7, 1, 0, 32'h9999_0000, 0, 1));
        dir.push_back(mk(0, 1, 32'h0000_9000, 32'h1, 4'h1, 9, 1, 0, 32'h0, 0, 1));
        foreach (dir[i]) issue(dir[i]);
        for (int i = 0; i < 60; i++) issue(rand_txn());
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);

        // Reset while waiting for a response; the late response must be ignored.
        slave_en = 1'b0;
        mem_read = 1'b1;
        addr     = 32'h0000_A004;
        n = 0;
        while (!bus_if.bus_req_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_test_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
        bus_if.bus_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_req_ready = 1'b0;
        chk("rst_test_in_wait_stall", 32'(stall), 32'd1);
        #2;
        rst      = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus_if.bus_req_valid), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rsp_rdata = 32'hFFFF_FFFF;
        bus_if.bus_rsp_err   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_err   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("late_rsp_r_data", r_data, 32'd0);
        chk("late_rsp_err", 32'(access_err), 32'd0);
        chk("late_rsp_valid", 32'(bus_if.bus_req_valid), 32'd0);
        chk("late_rsp_stall", 32'(stall), 32'd0);
        chk("late_rsp_we", 32'(bus_if.bus_req_we), 32'd0);
        chk("late_rsp_addr", bus_if.bus_req_addr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
